// File: rtl/alu_pkg.sv
// Shared types for the ALU result reader: flag layout and the packed FIFO entry.
package alu_pkg;
  localparam int unsigned ALU_FLAG_W = 3;
  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned FLAG_C     = 2;
  localparam int unsigned FLAG_V     = 1;
  localparam int unsigned FLAG_Z     = 0;

  typedef logic [ALU_FLAG_W-1:0] alu_flags_t;

  typedef struct packed {
    alu_flags_t            flags;
    logic [ALU_DATA_W-1:0] data;
  } alu_entry_t;
endpackage

// File: rtl/alu_result_reader_if.sv
// Register-watch inputs plus the valid/ready read port of the ALU result reader.
interface alu_result_reader_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  import alu_pkg::*;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              reg_en;
  logic [WIDTH-1:0]  reg_q;
  logic              reg_c;
  logic              reg_v;
  logic              reg_z;
  logic              rd_valid;
  logic              rd_ready;
  logic [WIDTH-1:0]  rd_data;
  alu_flags_t        rd_flags;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              drop;

  modport master (
    output reg_en, reg_q, reg_c, reg_v, reg_z, rd_ready,
    input  rd_valid, rd_data, rd_flags, count, full, drop
  );

  modport slave (
    input  reg_en, reg_q, reg_c, reg_v, reg_z, rd_ready,
    output rd_valid, rd_data, rd_flags, count, full, drop
  );
endinterface

// File: rtl/alu_result_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module alu_result_fifo_mem #(
  parameter int unsigned DW    = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DW-1:0]            i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DW-1:0]            o_rd_data
);
  logic [DW-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; occupancy is tracked by the caller.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/alu_result_reader.sv
// Samples the ALU result register one cycle after its write enable and queues samples.
// Optional ALU_READER_STICKY_EN adds sticky_clr / sticky_flags accumulation of pushed flags.
module alu_result_reader
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_reader_if.slave   bus
`ifdef ALU_READER_STICKY_EN
  ,
  input  logic                 sticky_clr,
  output alu_flags_t           sticky_flags
`endif
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = WIDTH + ALU_FLAG_W;

  logic               r_en_d;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_drop;

  logic               w_full;
  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  alu_flags_t         w_wr_flags;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && bus.rd_ready;
  // A full FIFO still accepts the sample when a pop frees a slot in the same cycle.
  assign w_push     = r_en_d && (!w_full || w_pop);
  assign w_wr_flags = {bus.reg_c, bus.reg_v, bus.reg_z};
  assign w_wr_entry = {w_wr_flags, bus.reg_q};

  alu_result_fifo_mem #(
    .DW    (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_entry)
  );

  // Pointers, occupancy, delayed enable and drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_en_d <= bus.reg_en;
      r_drop <= r_en_d && w_full && !w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.rd_valid = w_valid;
  assign bus.rd_data  = w_valid ? w_rd_entry[WIDTH-1:0] : '0;
  assign bus.rd_flags = w_valid ? w_rd_entry[ENTRY_W-1:WIDTH] : '0;
  assign bus.count    = r_count;
  assign bus.full     = w_full;
  assign bus.drop     = r_drop;

`ifdef ALU_READER_STICKY_EN
  alu_flags_t r_sticky;

  // A clear coinciding with an accepted push keeps only that push's flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (w_push) begin
      r_sticky <= sticky_clr ? w_wr_flags : (r_sticky | w_wr_flags);
    end else if (sticky_clr) begin
      r_sticky <= '0;
    end
  end

  assign sticky_flags = r_sticky;
`endif
endmodule

// File: tb/tb_alu_result_reader.sv
// Directed self-checking bench for alu_result_reader, with a model of the result register.
module tb_alu_result_reader;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  // Result register model: loads d_q/d_f on edges where reg_en is high.
  logic [WIDTH-1:0] d_q = '0;
  logic [2:0]       d_f = '0;
  logic [WIDTH-1:0] m_q;
  logic [2:0]       m_f;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      m_f <= '0;
    end else if (bus.reg_en) begin
      m_q <= d_q;
      m_f <= d_f;
    end
  end
  assign bus.reg_q = m_q;
  assign bus.reg_c = m_f[2];
  assign bus.reg_v = m_f[1];
  assign bus.reg_z = m_f[0];

`ifdef ALU_READER_STICKY_EN
  logic       sticky_clr = 1'b0;
  alu_flags_t sticky_flags;
`endif

  alu_result_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_READER_STICKY_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [WIDTH-1:0] v, input logic [2:0] f);
    bus.reg_en = 1'b1;
    d_q = v;
    d_f = f;
    tick();
    bus.reg_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.reg_en   = 1'b0;
    bus.rd_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.rd_valid); end
    total++; if (bus.full !== 1'b0 || bus.drop !== 1'b0) begin bad++; $display("FAIL reset_full_drop got=%b%b exp=00", bus.full, bus.drop); end
    total++; if (bus.rd_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.rd_data); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    capture(32'h0000_0005, 3'b000);
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", bus.rd_valid); end
    tick();
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.rd_valid); end
    total++; if (bus.rd_data !== 32'h5 || bus.rd_flags !== 3'b000) begin bad++; $display("FAIL single_data got=%h/%b exp=5/000", bus.rd_data, bus.rd_flags); end
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.count); end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    total++; if (bus.count !== 3'd0 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%0d/%b exp=0/0", bus.count, bus.rd_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) capture(32'h11 + 32'(i), 3'b000);
    total++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0d/%b exp=4/1", bus.count, bus.full); end
    total++; if (bus.drop !== 1'b0) begin bad++; $display("FAIL fill_early_drop got=%b exp=0", bus.drop); end
    tick();
    total++; if (bus.drop !== 1'b1 || bus.count !== 3'd4) begin bad++; $display("FAIL fill_drop got=%b/%0d exp=1/4", bus.drop, bus.count); end
    tick();
    total++; if (bus.drop !== 1'b0) begin bad++; $display("FAIL fill_drop_pulse got=%b exp=0", bus.drop); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.rd_data !== 32'h11 + 32'(i)) begin bad++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, bus.rd_data, 32'h11 + 32'(i)); end
      tick();
    end
    bus.rd_ready = 1'b0;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL fill_drained got=%0d exp=0", bus.count); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) capture(32'h21 + 32'(i), 3'b000);
    tick();
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fullpop_full got=%b exp=1", bus.full); end
    capture(32'h25, 3'b000);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    total++; if (bus.count !== 3'd4 || bus.drop !== 1'b0) begin bad++; $display("FAIL fullpop_count got=%0d/%b exp=4/0", bus.count, bus.drop); end
    total++; if (bus.rd_data !== 32'h22) begin bad++; $display("FAIL fullpop_head got=%h exp=22", bus.rd_data); end
    tick();
    total++; if (bus.drop !== 1'b0) begin bad++; $display("FAIL fullpop_nodrop got=%b exp=0", bus.drop); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.rd_data !== 32'h22 + 32'(i)) begin bad++; $display("FAIL fullpop_order[%0d] got=%h exp=%h", i, bus.rd_data, 32'h22 + 32'(i)); end
      tick();
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_v = 1;
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.reg_en = (c < 10);
      d_q = 32'(c + 1);
      d_f = 3'b000;
      tick();
      total++; if (bus.drop !== 1'b0) begin bad++; $display("FAIL wrap_drop[%0d] got=%b exp=0", c, bus.drop); end
      if (bus.rd_valid === 1'b1) begin
        total++; if (bus.rd_data !== 32'(exp_v)) begin bad++; $display("FAIL wrap_data got=%0d exp=%0d", bus.rd_data, exp_v); end
        exp_v++;
      end
    end
    bus.reg_en = 1'b0;
    bus.rd_ready = 1'b0;
    total++; if (exp_v !== 11) begin bad++; $display("FAIL wrap_total got=%0d exp=10", exp_v - 1); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL wrap_empty got=%0d exp=0", bus.count); end
  endtask

`ifdef ALU_READER_STICKY_EN
  task automatic test_sticky();
    total++; if (sticky_flags !== 3'b000) begin bad++; $display("FAIL sticky_init got=%b exp=000", sticky_flags); end
    bus.rd_ready = 1'b1;
    capture(32'h1, 3'b100);
    capture(32'h2, 3'b010);
    tick();
    total++; if (sticky_flags !== 3'b110) begin bad++; $display("FAIL sticky_or got=%b exp=110", sticky_flags); end
    capture(32'h3, 3'b001);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    bus.rd_ready = 1'b0;
    total++; if (sticky_flags !== 3'b001) begin bad++; $display("FAIL sticky_clr_push got=%b exp=001", sticky_flags); end
    for (int i = 0; i < 3; i++) capture(32'h4 + 32'(i), 3'b000);
    tick();
    capture(32'h7, 3'b111);
    tick();
    total++; if (bus.drop !== 1'b1 || sticky_flags !== 3'b001) begin bad++; $display("FAIL sticky_drop got=%b/%b exp=1/001", bus.drop, sticky_flags); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.rd_ready = 1'b0;
  endtask
`endif

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) capture(32'hA1 + 32'(i), 3'b000);
    tick();
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL midrst_pre got=%0d exp=3", bus.count); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.count !== 3'd0 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_async got=%0d/%b exp=0/0", bus.count, bus.rd_valid); end
    total++; if (bus.rd_data !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h exp=0", bus.rd_data); end
    bus.reg_en = 1'b1;
    d_q = 32'hDEAD;
    tick();
    rst_n = 1'b1;
    bus.reg_en = 1'b0;
    tick();
    tick();
    total++; if (bus.count !== 3'd0 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_nocapture got=%0d/%b exp=0/0", bus.count, bus.rd_valid); end
  endtask

  initial begin
    bus.reg_en   = 1'b0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_wrap();
`ifdef ALU_READER_STICKY_EN
    test_sticky();
`endif
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
